// File: rtl/factorial_ctrl.sv
// Sequencer for the 8-bit factorial datapath: R0 holds the counter, R1 the product.
// Build option FACT_CTRL_ZERO_EN adds the ZCHK state so that N = 0 yields 0! = 1.
module factorial_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       compare,
  output logic       IE,
  output logic       we,
  output logic [1:0] wa,
  output logic       rea,
  output logic       reb,
  output logic [1:0] raa,
  output logic [1:0] rab,
  output logic [2:0] Sel_alu,
  output logic       OE,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // IDLE  | waiting for start, all controls low
  // LOAD  | R0 <- Data_i
  // CLR   | R1 <- R0 - R0
  // INIT  | R1 <- R1 + 1
  // CHK   | test R0 == 1
  // ZCHK  | test R0 == 0 (FACT_CTRL_ZERO_EN only)
  // MUL   | R1 <- R1 * R0
  // DEC   | R0 <- R0 - 1
  // OUT   | output register <- R1
  // DONE  | one-cycle done pulse
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_CLR  = 4'd2,
    S_INIT = 4'd3,
    S_CHK  = 4'd4,
    S_ZCHK = 4'd5,
    S_MUL  = 4'd6,
    S_DEC  = 4'd7,
    S_OUT  = 4'd8,
    S_DONE = 4'd9
  } state_t;

  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_MUL   = 3'b010;
  localparam logic [2:0] ALU_PASSA = 3'b011;
  localparam logic [2:0] ALU_INCA  = 3'b100;
  localparam logic [2:0] ALU_DECA  = 3'b101;

  typedef struct packed {
    logic       ie;
    logic       we;
    logic [1:0] wa;
    logic       rea;
    logic       reb;
    logic [1:0] raa;
    logic [1:0] rab;
    logic [2:0] sel;
    logic       oe;
    logic       busy;
    logic       done;
  } ctrl_t;

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  function automatic state_t next_state(input state_t s, input logic st, input logic cmp);
    state_t n;
    n = S_IDLE;
    case (s)
      S_IDLE: n = st ? S_LOAD : S_IDLE;
      S_LOAD: n = S_CLR;
      S_CLR:  n = S_INIT;
      S_INIT: n = S_CHK;
`ifdef FACT_CTRL_ZERO_EN
      S_CHK:  n = cmp ? S_OUT : S_ZCHK;
      S_ZCHK: n = cmp ? S_OUT : S_MUL;
`else
      S_CHK:  n = cmp ? S_OUT : S_MUL;
`endif
      S_MUL:  n = S_DEC;
      S_DEC:  n = S_CHK;
      S_OUT:  n = S_DONE;
      S_DONE: n = S_IDLE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    c.busy = (s != S_IDLE);
    case (s)
      S_LOAD: begin
        c.ie = 1'b1; c.we = 1'b1; c.wa = 2'd0;
      end
      S_CLR: begin
        c.rea = 1'b1; c.reb = 1'b1; c.raa = 2'd0; c.rab = 2'd0;
        c.sel = ALU_SUB; c.we = 1'b1; c.wa = 2'd1;
      end
      S_INIT: begin
        c.rea = 1'b1; c.raa = 2'd1; c.sel = ALU_INCA; c.we = 1'b1; c.wa = 2'd1;
      end
      S_CHK: begin
        c.rea = 1'b1; c.raa = 2'd0; c.sel = ALU_PASSA;
      end
      S_ZCHK: begin
        c.rea = 1'b1; c.raa = 2'd0; c.sel = ALU_INCA;
      end
      S_MUL: begin
        c.rea = 1'b1; c.reb = 1'b1; c.raa = 2'd1; c.rab = 2'd0;
        c.sel = ALU_MUL; c.we = 1'b1; c.wa = 2'd1;
      end
      S_DEC: begin
        c.rea = 1'b1; c.raa = 2'd0; c.sel = ALU_DECA; c.we = 1'b1; c.wa = 2'd0;
      end
      S_OUT: begin
        c.rea = 1'b1; c.raa = 2'd1; c.sel = ALU_PASSA; c.oe = 1'b1;
      end
      S_DONE: c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign state_nxt = next_state(state, start, compare);

  // Controls are registered from the next state so they always match the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ctrl  <= '0;
    end else begin
      state <= state_nxt;
      ctrl  <= decode(state_nxt);
    end
  end

  assign IE      = ctrl.ie;
  assign we      = ctrl.we;
  assign wa      = ctrl.wa;
  assign rea     = ctrl.rea;
  assign reb     = ctrl.reb;
  assign raa     = ctrl.raa;
  assign rab     = ctrl.rab;
  assign Sel_alu = ctrl.sel;
  assign OE      = ctrl.oe;
  assign busy    = ctrl.busy;
  assign done    = ctrl.done;

endmodule

// File: tb/tb_factorial_ctrl.sv
// Self-checking bench for factorial_ctrl: a behavioural datapath closes the loop,
// and an expected control trace plus N! mod 256 is checked every cycle.
module tb_factorial_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       compare;
  logic       IE, we, rea, reb, OE, busy, done;
  logic [1:0] wa, raa, rab;
  logic [2:0] Sel_alu;

  int n_vec = 0;
  int n_err = 0;

  factorial_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .compare(compare),
    .IE(IE), .we(we), .wa(wa), .rea(rea), .reb(reb), .raa(raa), .rab(rab),
    .Sel_alu(Sel_alu), .OE(OE), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural datapath
  logic [7:0] data_i = 8'd0;
  logic [7:0] rf [4];
  logic [7:0] out_q = 8'hA5;
  logic [7:0] a_v, b_v, y_v;

  assign a_v = rea ? rf[raa] : 8'd0;
  assign b_v = reb ? rf[rab] : 8'd0;
  always_comb begin
    y_v = 8'd0;
    case (Sel_alu)
      3'b000: y_v = a_v + b_v;
      3'b001: y_v = a_v - b_v;
      3'b010: y_v = a_v * b_v;
      3'b011: y_v = a_v;
      3'b100: y_v = a_v + 8'd1;
      3'b101: y_v = a_v - 8'd1;
      default: y_v = 8'd0;
    endcase
  end
  assign compare = (y_v == 8'd1);

  initial for (int i = 0; i < 4; i++) rf[i] = 8'd0;

  always @(posedge clk) begin
    if (we) rf[wa] <= IE ? data_i : y_v;
    if (OE) out_q <= y_v;
  end

  // Control vector layout: {IE,we,wa,rea,reb,raa,rab,Sel_alu,OE,busy,done}
  localparam logic [15:0] V_IDLE = 16'b0_0_00_0_0_00_00_000_0_0_0;
  localparam logic [15:0] V_LOAD = 16'b1_1_00_0_0_00_00_000_0_1_0;
  localparam logic [15:0] V_CLR  = 16'b0_1_01_1_1_00_00_001_0_1_0;
  localparam logic [15:0] V_INIT = 16'b0_1_01_1_0_01_00_100_0_1_0;
  localparam logic [15:0] V_CHK  = 16'b0_0_00_1_0_00_00_011_0_1_0;
  localparam logic [15:0] V_ZCHK = 16'b0_0_00_1_0_00_00_100_0_1_0;
  localparam logic [15:0] V_MUL  = 16'b0_1_01_1_1_01_00_010_0_1_0;
  localparam logic [15:0] V_DEC  = 16'b0_1_00_1_0_00_00_101_0_1_0;
  localparam logic [15:0] V_OUT  = 16'b0_0_00_1_0_01_00_011_1_1_0;
  localparam logic [15:0] V_DONE = 16'b0_0_00_0_0_00_00_000_0_1_1;

  logic [15:0] act;
  assign act = {IE, we, wa, rea, reb, raa, rab, Sel_alu, OE, busy, done};

  typedef struct {
    logic [15:0] v;
    bit          chk_out;
    logic [7:0]  out;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_vec(input logic [15:0] v, input bit c, input logic [7:0] o);
    exp_t e;
    e.v = v; e.chk_out = c; e.out = o;
    exp_q.push_back(e);
  endtask

  // Expected schedule for one run: state walk from the counter value, result from N!.
  task automatic push_run(input logic [7:0] n);
    logic [7:0] acc;
    logic [7:0] cnt;
    acc = 8'd1;
    for (int i = 2; i <= int'(n); i++) acc = acc * i[7:0];
    push_vec(V_LOAD, 0, 0);
    push_vec(V_CLR, 0, 0);
    push_vec(V_INIT, 0, 0);
    cnt = n;
    for (int g = 0; g < 300; g++) begin
      push_vec(V_CHK, 0, 0);
      if (cnt == 8'd1) break;
`ifdef FACT_CTRL_ZERO_EN
      push_vec(V_ZCHK, 0, 0);
      if (cnt == 8'd0) break;
`endif
      push_vec(V_MUL, 0, 0);
      push_vec(V_DEC, 0, 0);
      cnt = cnt - 8'd1;
    end
    push_vec(V_OUT, 0, 0);
    push_vec(V_DONE, 1, acc);
  endtask

  // Per-cycle compare against the expected schedule; empty schedule means idle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctrl", {16'd0, act}, {16'd0, e.v});
      if (e.chk_out) check("out", {24'd0, out_q}, {24'd0, e.out});
    end else begin
      check("ctrl_idle", {16'd0, act}, {16'd0, V_IDLE});
    end
  end

  // One run; returns cycles from the start-sampling edge to the DONE cycle.
  task automatic run(input logic [7:0] n, input bit noisy, output int lat);
    @(negedge clk); #1;
    data_i = n;
    start = 1'b1;
    push_run(n);
    lat = -1;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk); #1;
      if (j == 2) data_i = ~n;
      if (done) begin
        lat = j;
        start = 1'b0;
        break;
      end
      start = noisy;
    end
    start = 1'b0;
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk); #1;
  endtask

  task automatic drain;
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 32'd0, 32'd1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [7:0] out_before;
    logic [7:0] r1_before;

    #3;
    check("reset_ctrl", {16'd0, act}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;

`ifdef FACT_CTRL_ZERO_EN
    run(8'd5, 0, lat);
    check("n5_out", {24'd0, out_q}, 32'h78);
    check("n5_lat", lat, 22);
    run(8'd1, 0, lat);
    check("n1_out", {24'd0, out_q}, 32'h01);
    check("n1_lat", lat, 6);
    run(8'd0, 0, lat);
    check("n0_out", {24'd0, out_q}, 32'h01);
    check("n0_lat", lat, 7);
    run(8'd6, 0, lat);
    check("n6_out", {24'd0, out_q}, 32'hD0);
    check("n6_lat", lat, 26);
`else
    run(8'd5, 0, lat);
    check("n5_out", {24'd0, out_q}, 32'h78);
    check("n5_lat", lat, 18);
    run(8'd1, 0, lat);
    check("n1_out", {24'd0, out_q}, 32'h01);
    check("n1_lat", lat, 6);
    run(8'd6, 0, lat);
    check("n6_out", {24'd0, out_q}, 32'hD0);
    check("n6_lat", lat, 21);
`endif

    run(8'd4, 1, lat);
    check("noisy_out", {24'd0, out_q}, 32'h18);

    run(8'd7, 0, lat);
    check("n7_out", {24'd0, out_q}, 32'hB0);

    // start held high: two runs with a single idle cycle between them
    @(negedge clk); #1;
    data_i = 8'd3;
    start = 1'b1;
    push_run(8'd3);
    push_vec(V_IDLE, 0, 0);
    push_run(8'd2);
    @(negedge clk); #1;
    @(negedge clk); #1;
    data_i = 8'd2;
    while (!done) begin
      @(negedge clk); #1;
    end
    check("held_out1", {24'd0, out_q}, 32'h06);
    @(negedge clk); #1;
    check("held_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    start = 1'b0;
    drain();
    check("held_out2", {24'd0, out_q}, 32'h02);

    // reset during the first MUL of an N=5 run
    @(negedge clk); #1;
    data_i = 8'd5;
    start = 1'b1;
    push_run(8'd5);
    @(negedge clk); #1;
    start = 1'b0;
`ifdef FACT_CTRL_ZERO_EN
    repeat (5) @(negedge clk);
`else
    repeat (4) @(negedge clk);
`endif
    #1;
    check("mid_is_mul", {29'd0, Sel_alu}, 32'd2);
    out_before = out_q;
    r1_before = rf[1];
    rst = 1'b1;
    #1;
    check("rst_ctrl", {16'd0, act}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out", {24'd0, out_q}, {24'd0, out_before});
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_no_write", {24'd0, rf[1]}, {24'd0, r1_before});
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    run(8'd3, 0, lat);
    check("n3_out", {24'd0, out_q}, 32'h06);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
